// File: rtl/sata_rx_prim_decode.sv
// -----------------------------------------------------------------------------
// sata_rx_prim_decode
//
// Classifies aligned 32-bit receive words into SATA primitives, payload data
// or illegal words. Optionally expands CONT-compressed primitive streams.
// ALIGN primitives are removed from the stream.
//
// Build option:
//   SATA_RX_CONT_EN  defined   : CONT enters a REPEAT state. In that state,
//                                scrambled data words are replaced by the last
//                                primitive. A CONT with no valid last primitive
//                                is reported on code_err.
//                    undefined : no REPEAT state. CONT is reported like any
//                                other primitive (prim_code 1).
//
// Ports:
//   rx_clkin    in   receive word clock (shared with the aligner)
//   rx_reset    in   synchronous active-high reset
//   rx_outen    in   word strobe; rx_datain/rx_ctrlin are valid when 1
//   rx_syncout  in   aligner locked to the ALIGN boundary
//   rx_datain   in   aligned word, byte0 in [7:0]
//   rx_ctrlin   in   K-character flags, bit n for byte n
//   prim_valid  out  one-cycle pulse: prim_code is valid
//   prim_code   out  primitive code (ALIGN=0 ... X_RDY=17), held between pulses
//   data_valid  out  one-cycle pulse: data_out is a payload word
//   data_out    out  payload word, held between pulses
//   code_err    out  one-cycle pulse: illegal word or orphan CONT
//
// All outputs are registered. Each one responds one cycle after the strobed
// input word.
// -----------------------------------------------------------------------------
module sata_rx_prim_decode (
    input  logic        rx_clkin,
    input  logic        rx_reset,
    input  logic        rx_outen,
    input  logic        rx_syncout,
    input  logic [31:0] rx_datain,
    input  logic [3:0]  rx_ctrlin,
    output logic        prim_valid,
    output logic [4:0]  prim_code,
    output logic        data_valid,
    output logic [31:0] data_out,
    output logic        code_err
);

    localparam logic [4:0] CODE_ALIGN = 5'd0;
`ifdef SATA_RX_CONT_EN
    localparam logic [4:0] CODE_CONT  = 5'd1;
`endif

    typedef enum logic [1:0] {
        KIND_DATA,
        KIND_PRIM,
        KIND_ILLEGAL
    } word_kind_t;

    // Returns {hit, code} for a K28.3/K28.5-led primitive pattern.
    function automatic logic [5:0] prim_lookup(input logic [31:0] w);
        case (w)
            32'h7B4A4ABC: prim_lookup = {1'b1, 5'd0};   // ALIGN
            32'h9999AA7C: prim_lookup = {1'b1, 5'd1};   // CONT
            32'h3636B57C: prim_lookup = {1'b1, 5'd2};   // DMAT
            32'hD5D5B57C: prim_lookup = {1'b1, 5'd3};   // EOF
            32'hD5D5AA7C: prim_lookup = {1'b1, 5'd4};   // HOLD
            32'h9595AA7C: prim_lookup = {1'b1, 5'd5};   // HOLDA
            32'h9595957C: prim_lookup = {1'b1, 5'd6};   // PMACK
            32'hF5F5957C: prim_lookup = {1'b1, 5'd7};   // PMNAK
            32'h1717B57C: prim_lookup = {1'b1, 5'd8};   // PMREQ_P
            32'h7575957C: prim_lookup = {1'b1, 5'd9};   // PMREQ_S
            32'h5656B57C: prim_lookup = {1'b1, 5'd10};  // R_ERR
            32'h5555B57C: prim_lookup = {1'b1, 5'd11};  // R_IP
            32'h3535B57C: prim_lookup = {1'b1, 5'd12};  // R_OK
            32'h4A4A957C: prim_lookup = {1'b1, 5'd13};  // R_RDY
            32'h3737B57C: prim_lookup = {1'b1, 5'd14};  // SOF
            32'hB5B5957C: prim_lookup = {1'b1, 5'd15};  // SYNC
            32'h5858B57C: prim_lookup = {1'b1, 5'd16};  // WTRM
            32'h5757B57C: prim_lookup = {1'b1, 5'd17};  // X_RDY
            default:      prim_lookup = 6'd0;
        endcase
    endfunction

    logic       match_hit;
    logic [4:0] match_code;
    word_kind_t kind;

    assign {match_hit, match_code} = prim_lookup(rx_datain);

    // Only a single K-char in byte0 can be a primitive. Any other K-flag
    // pattern is a framing error.
    always_comb begin
        if (rx_ctrlin == 4'b0000)
            kind = KIND_DATA;
        else if (rx_ctrlin == 4'b0001 && match_hit)
            kind = KIND_PRIM;
        else
            kind = KIND_ILLEGAL;
    end

`ifdef SATA_RX_CONT_EN
    typedef enum logic {
        ST_IDLE,
        ST_REPEAT
    } state_t;

    state_t     state, state_d;
    logic       last_ok, last_ok_d;      // last_prim holds a repeatable primitive
    logic [4:0] last_prim, last_prim_d;
`endif

    logic        prim_valid_d;
    logic [4:0]  prim_code_d;
    logic        data_valid_d;
    logic [31:0] data_out_d;
    logic        code_err_d;

    // NOTE: every always_comb output is assigned a default before any branch,
    // so that no path can leave one unassigned and infer a latch.
    always_comb begin
        prim_valid_d = 1'b0;
        data_valid_d = 1'b0;
        code_err_d   = 1'b0;
        prim_code_d  = prim_code;
        data_out_d   = data_out;
`ifdef SATA_RX_CONT_EN
        state_d      = state;
        last_ok_d    = last_ok;
        last_prim_d  = last_prim;
`endif
        if (!rx_syncout) begin
            // Loss of lock invalidates the repeat context, strobe or not.
`ifdef SATA_RX_CONT_EN
            state_d   = ST_IDLE;
            last_ok_d = 1'b0;
`endif
        end else if (rx_outen) begin
            case (kind)
                KIND_DATA: begin
`ifdef SATA_RX_CONT_EN
                    if (state == ST_REPEAT) begin
                        // Scrambled filler after CONT stands for the last primitive.
                        prim_valid_d = 1'b1;
                        prim_code_d  = last_prim;
                    end else begin
                        data_valid_d = 1'b1;
                        data_out_d   = rx_datain;
                    end
`else
                    data_valid_d = 1'b1;
                    data_out_d   = rx_datain;
`endif
                end
                KIND_PRIM: begin
                    if (match_code == CODE_ALIGN) begin
                        // ALIGN is invisible: no pulse and no state change.
                    end
`ifdef SATA_RX_CONT_EN
                    else if (match_code == CODE_CONT) begin
                        // A repeated CONT inside REPEAT is ignored.
                        if (state == ST_IDLE) begin
                            if (last_ok)
                                state_d = ST_REPEAT;
                            else
                                code_err_d = 1'b1;
                        end
                    end
`endif
                    else begin
                        prim_valid_d = 1'b1;
                        prim_code_d  = match_code;
`ifdef SATA_RX_CONT_EN
                        last_prim_d  = match_code;
                        last_ok_d    = 1'b1;
                        state_d      = ST_IDLE;
`endif
                    end
                end
                default: begin
                    code_err_d = 1'b1;
`ifdef SATA_RX_CONT_EN
                    last_ok_d  = 1'b0;
                    state_d    = ST_IDLE;
`endif
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge rx_clkin) begin
        if (rx_reset) begin
            prim_valid <= 1'b0;
            prim_code  <= 5'd0;
            data_valid <= 1'b0;
            data_out   <= 32'd0;
            code_err   <= 1'b0;
`ifdef SATA_RX_CONT_EN
            state      <= ST_IDLE;
            last_ok    <= 1'b0;
            last_prim  <= 5'd0;
`endif
        end else begin
            prim_valid <= prim_valid_d;
            prim_code  <= prim_code_d;
            data_valid <= data_valid_d;
            data_out   <= data_out_d;
            code_err   <= code_err_d;
`ifdef SATA_RX_CONT_EN
            state      <= state_d;
            last_ok    <= last_ok_d;
            last_prim  <= last_prim_d;
`endif
        end
    end

endmodule

// File: doc/sata_rx_prim_decode.md
SATA_RX_PRIM_DECODE -- requirements
Module: sata_rx_prim_decode

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on posedge rx_clkin.
REQ-002 rx_clkin  in  1  receive word clock, shared with the aligner.
REQ-003 rx_reset  in  1  synchronous active-high reset.
REQ-004 rx_outen  in  1  word strobe; input word is valid only in cycles where this is 1.
REQ-005 rx_syncout  in  1  aligner locked to ALIGN boundary.
REQ-006 rx_datain  in  32  aligned word, byte0 in [7:0].
REQ-007 rx_ctrlin  in  4  K-char flags, bit n for byte n.
REQ-008 prim_valid  out  1  one-cycle pulse: prim_code is valid.
REQ-009 prim_code  out  5  primitive code (REQ-013).
REQ-010 data_valid  out  1  one-cycle pulse: data_out is a payload word.
REQ-011 data_out  out  32  payload word.
REQ-012 code_err  out  1  one-cycle pulse: illegal word or orphan CONT.

Function
REQ-013 Primitive codes SHALL be: ALIGN=0 7B4A4ABC, CONT=1 9999AA7C, DMAT=2 3636B57C, EOF=3 D5D5B57C, HOLD=4 D5D5AA7C, HOLDA=5 9595AA7C, PMACK=6 9595957C, PMNAK=7 F5F5957C, PMREQ_P=8 1717B57C, PMREQ_S=9 7575957C, R_ERR=10 5656B57C, R_IP=11 5555B57C, R_OK=12 3535B57C, R_RDY=13 4A4A957C, SOF=14 3737B57C, SYNC=15 B5B5957C, WTRM=16 5858B57C, X_RDY=17 5757B57C.
REQ-014 Classification: ctrl=0001 with a REQ-013 match -> primitive; ctrl=0000 -> data; any other ctrl value, or ctrl=0001 without a match -> illegal.
REQ-015 All outputs SHALL be registered; response appears exactly 1 cycle after the strobed input word.
REQ-016 In cycles with rx_outen=0, state SHALL hold and all pulse outputs SHALL be 0 the next cycle.
REQ-017 ALIGN SHALL be dropped: no pulse, no state change, including while in REPEAT.
REQ-018 Data word in IDLE -> data_valid=1, data_out=word; prim_valid=0.
REQ-019 Non-ALIGN, non-CONT primitive -> prim_valid=1, prim_code=code; last_prim register <= code, last_ok <= 1; state <= IDLE.
REQ-020 Illegal word -> code_err=1; last_ok <= 0; state <= IDLE.
REQ-021 CONT in IDLE with last_ok=1 -> state <= REPEAT, no pulse; CONT with last_ok=0 -> code_err=1, state stays IDLE.
REQ-022 REPEAT: each data word SHALL be suppressed and SHALL instead emit prim_valid=1, prim_code=last_prim; data_valid stays 0.
REQ-023 REPEAT: a further CONT SHALL be ignored; any other primitive exits per REQ-019 in the same cycle.
REQ-024 rx_syncout=0 -> no pulses next cycle; state <= IDLE; last_ok <= 0; this takes priority over word classification.
REQ-025 data_out and prim_code SHALL hold their last value when the corresponding valid is 0.

Reset
REQ-026 rx_reset=1 SHALL force state=IDLE, last_ok=0, last_prim=0, and all outputs to 0 on the next edge; it overrides every other input.
REQ-027 Reset asserted while in REPEAT SHALL abandon the repeat; the first word after reset SHALL be decoded as in IDLE.

Configuration
REQ-028 Macro SATA_RX_CONT_EN defined: CONT handling per REQ-021..023.
REQ-029 Macro SATA_RX_CONT_EN undefined: no REPEAT state; CONT SHALL be reported as prim_valid with prim_code=1, and data words always take REQ-018.

Verification
REQ-030 Reset, then sync=1, words HOLD, CONT, 3 scrambled data words, R_IP, all strobed -> prim 4, 4, 4, 4, then prim 11; data_valid never 1.
REQ-031 sync=1, rx_outen alternating 1/0, words SOF, 0x12345678 (ctrl 0000), EOF -> prim 14, data 0x12345678, prim 3, each 1 cycle after its strobe; idle cycles produce no pulses.
REQ-032 After reset, CONT as first word -> code_err=1; a following data word 0xDEADBEEF -> data_valid, not a repeat.
REQ-033 In REPEAT after X_RDY, ALIGN then data then CONT then data -> prim 17 twice, no ALIGN output; drop rx_syncout for 1 cycle then data 0xA5A5A5A5 -> data_valid.
REQ-034 ctrl=0011 word, and ctrl=0001 with 0x0000007C -> code_err=1 each; rx_reset mid-REPEAT, then data 0x1 -> data_valid=1.
REQ-035 Build without SATA_RX_CONT_EN, stimulus of REQ-030 -> prim 4, prim 1, 3 data pulses, prim 11.
